// File: rtl/ifetch.sv
// Instruction fetch: reads short (1-word) and long (2-word) instructions over a classic bus into ir_o/pc_o.
// Latency: instruction on ir_o at the edge after its last ack; zero-wait bus gives 1 short/clk, 1 long/2 clk.
// Backpressure: stall_i freezes ir_o/pc_o; a completed instruction parks and the bus idles until stall_i drops.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        pc_set_i,
    input  logic [31:0] pc_target_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic        bus_we_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_dat_i,
    output logic [63:0] ir_o,
    output logic [31:0] pc_o
);

    typedef enum logic [1:0] {
        F1   = 2'd0,
        F2   = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] fpc_q;
    logic [31:0] op_q;
    logic [31:0] op_pc_q;
    logic [63:0] park_ir_q;
    logic [31:0] park_pc_q;

    logic        accept;
    logic        complete;
    logic [63:0] asm_ir;
    logic [31:0] asm_pc;
    logic [31:0] tgt_aligned;

    // Redirect targets are always word aligned.
    assign tgt_aligned = pc_target_i & 32'hFFFF_FFFC;

    // Bus request is live in F1/F2, dropped during a redirect cycle and while reset is held.
    assign bus_cyc_o = (state_q != HOLD) & ~pc_set_i & ~rst_i;
    assign bus_stb_o = bus_cyc_o;
    assign bus_adr_o = fpc_q;
    assign bus_sel_o = 4'hF;
    assign bus_we_o  = 1'b0;
    assign accept    = bus_cyc_o & bus_ack_i;

    // Assemble the instruction that would complete if the current word is accepted.
    always_comb begin
        complete = 1'b0;
        asm_ir   = 64'h0;
        asm_pc   = fpc_q;
        if (state_q == F1) begin
            complete = ~bus_dat_i[0];
            asm_ir   = {32'h0, bus_dat_i};
            asm_pc   = fpc_q;
        end else if (state_q == F2) begin
            complete = 1'b1;
            asm_ir   = {bus_dat_i, op_q};
            asm_pc   = op_pc_q;
        end
    end

    // Fetch FSM with registered instruction outputs; redirect beats every other event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= F1;
            fpc_q     <= RESET_PC;
            op_q      <= 32'h0;
            op_pc_q   <= 32'h0;
            park_ir_q <= 64'h0;
            park_pc_q <= 32'h0;
            ir_o      <= 64'h0;
            pc_o      <= 32'h0;
        end else if (pc_set_i) begin
            fpc_q   <= tgt_aligned;
            state_q <= F1;
            ir_o    <= 64'h0;
        end else if (state_q == HOLD) begin
            if (!stall_i) begin
                ir_o    <= park_ir_q;
                pc_o    <= park_pc_q;
                state_q <= F1;
            end
        end else if (accept) begin
            fpc_q <= fpc_q + 32'd4;
            if (!complete) begin
                // Long-form opcode: keep it and its address, fetch the immediate next.
                op_q    <= bus_dat_i;
                op_pc_q <= fpc_q;
                state_q <= F2;
                if (!stall_i) begin
                    ir_o <= 64'h0;
                end
            end else if (stall_i) begin
                park_ir_q <= asm_ir;
                park_pc_q <= asm_pc;
                state_q   <= HOLD;
            end else begin
                ir_o    <= asm_ir;
                pc_o    <= asm_pc;
                state_q <= F1;
            end
        end else if (!stall_i) begin
            ir_o <= 64'h0;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed vector table, hand sequences for multi-cycle corners, then random traffic.
// Expected values come from constants or a transaction-level model of the fetch rules.
// Memory is a 256-word array answering on bus_adr_o[9:2].
module tb_ifetch;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        pc_set_i;
    logic [31:0] pc_target_i;
    logic        bus_cyc_o;
    logic        bus_stb_o;
    logic [31:0] bus_adr_o;
    logic [3:0]  bus_sel_o;
    logic        bus_we_o;
    logic        bus_ack_i;
    logic [31:0] bus_dat_i;
    logic [63:0] ir_o;
    logic [31:0] pc_o;

    logic [31:0] mem [0:255];

    int n_pass;
    int n_total;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .pc_set_i    (pc_set_i),
        .pc_target_i (pc_target_i),
        .bus_cyc_o   (bus_cyc_o),
        .bus_stb_o   (bus_stb_o),
        .bus_adr_o   (bus_adr_o),
        .bus_sel_o   (bus_sel_o),
        .bus_we_o    (bus_we_o),
        .bus_ack_i   (bus_ack_i),
        .bus_dat_i   (bus_dat_i),
        .ir_o        (ir_o),
        .pc_o        (pc_o)
    );

    assign bus_dat_i = mem[bus_adr_o[9:2]];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        stall;
        logic        set;
        logic [31:0] tgt;
        logic        ack;
        logic        e_cyc;
        logic [31:0] e_adr;
        logic [63:0] e_ir;
        logic        chk_pc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Apply inputs just after an edge and let combinational outputs settle.
    task automatic drive(input logic s, input logic p, input logic [31:0] t, input logic a);
        stall_i     = s;
        pc_set_i    = p;
        pc_target_i = t;
        bus_ack_i   = a;
        #2;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference model state (random phase)
    logic [31:0] m_adr, m_ipc, m_ppc, m_pc, w;
    logic [63:0] m_pir, m_ir, inst;
    logic        m_pend, got, e_cyc;
    logic [31:0] m_part [$];
    logic        r_stall, r_set, r_ack;
    logic [31:0] r_tgt;

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_i = 1'b1;
        stall_i = 1'b0;
        pc_set_i = 1'b0;
        pc_target_i = 32'h0;
        bus_ack_i = 1'b0;

        for (int i = 0; i < 256; i++) mem[i] = 32'hFACE_0000 | (i << 4);
        mem[0]   = 32'h0000_1000;
        mem[1]   = 32'h0000_2000;
        mem[2]   = 32'h0000_3000;
        mem[3]   = 32'h0000_4000;
        mem[4]   = 32'h0000_0001;
        mem[5]   = 32'hDEAD_BEEF;
        mem[6]   = 32'h0000_5000;
        mem[8]   = 32'h0000_6000;
        mem[9]   = 32'h0000_7000;
        mem[10]  = 32'h0000_8000;
        mem[11]  = 32'h0000_0003;
        mem[12]  = 32'h1234_5678;
        mem[64]  = 32'h0000_9000;
        mem[65]  = 32'h0000_0005;
        mem[255] = 32'h0000_A000;

        //            stall set tgt   ack cyc adr     ir                         chkpc pc
        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 64'h0000_0000_0000_1000, 1'b1, 32'h00};
        tbl[1] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 64'h0000_0000_0000_2000, 1'b1, 32'h04};
        tbl[2] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 64'h0000_0000_0000_3000, 1'b1, 32'h08};
        tbl[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 64'h0000_0000_0000_4000, 1'b1, 32'h0C};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 64'h0,                   1'b0, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 64'hDEAD_BEEF_0000_0001, 1'b1, 32'h10};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h18, 64'h0000_0000_0000_5000, 1'b1, 32'h18};

        // Reset state
        #2;
        check("rst_cyc", bus_cyc_o, 1'b0);
        check("rst_stb", bus_stb_o, 1'b0);
        check("rst_ir", ir_o, 64'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_sel", bus_sel_o, 4'hF);
        check("rst_we", bus_we_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;

        // Directed table: short words back to back, then a long instruction
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i].stall, tbl[i].set, tbl[i].tgt, tbl[i].ack);
            check($sformatf("tbl%0d_cyc", i), bus_cyc_o, tbl[i].e_cyc);
            if (tbl[i].e_cyc) check($sformatf("tbl%0d_adr", i), bus_adr_o, tbl[i].e_adr);
            tick();
            check($sformatf("tbl%0d_ir", i), ir_o, tbl[i].e_ir);
            if (tbl[i].chk_pc) check($sformatf("tbl%0d_pc", i), pc_o, tbl[i].e_pc);
        end

        // Redirect to 0x20, then two wait states per ack
        drive(1'b0, 1'b1, 32'h20, 1'b1);
        check("ws_set_cyc", bus_cyc_o, 1'b0);
        tick();
        check("ws_set_ir", ir_o, 64'h0);
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b0, 1'b0, 32'h0, (j == 2));
                check("ws_cyc", bus_cyc_o, 1'b1);
                check("ws_adr", bus_adr_o, 32'h20 + 32'(k * 4));
                tick();
                if (j < 2) check("ws_bubble", ir_o, 64'h0);
            end
            check("ws_ir", ir_o, (k == 0) ? 64'h6000 : 64'h7000);
            check("ws_pc", pc_o, 32'h20 + 32'(k * 4));
        end

        // Stall for three cycles while the next instruction completes
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        check("st_adr", bus_adr_o, 32'h28);
        tick();
        check("st_hold_ir0", ir_o, 64'h7000);
        for (int j = 0; j < 2; j++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b1);
            check("st_hold_cyc", bus_cyc_o, 1'b0);
            tick();
            check("st_hold_ir", ir_o, 64'h7000);
            check("st_hold_pc", pc_o, 32'h24);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("st_rel_cyc", bus_cyc_o, 1'b0);
        tick();
        check("st_rel_ir", ir_o, 64'h8000);
        check("st_rel_pc", pc_o, 32'h28);

        // Redirect during F2 with a coincident ack
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_op_adr", bus_adr_o, 32'h2C);
        tick();
        check("rd_op_ir", ir_o, 64'h0);
        drive(1'b0, 1'b1, 32'h103, 1'b1);
        check("rd_cyc", bus_cyc_o, 1'b0);
        tick();
        check("rd_ir", ir_o, 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("rd_adr", bus_adr_o, 32'h100);
        tick();
        check("rd_next_ir", ir_o, 64'h9000);
        check("rd_next_pc", pc_o, 32'h100);

        // Asynchronous reset in the middle of F2
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("ar_f2_cyc", bus_cyc_o, 1'b1);
        check("ar_f2_adr", bus_adr_o, 32'h108);
        #1 rst_i = 1'b1;
        #1;
        check("ar_cyc", bus_cyc_o, 1'b0);
        check("ar_stb", bus_stb_o, 1'b0);
        check("ar_ir", ir_o, 64'h0);
        check("ar_pc", pc_o, 32'h0);
        tick();
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("ar_rel_cyc", bus_cyc_o, 1'b1);
        check("ar_rel_adr", bus_adr_o, 32'h0);
        tick();
        check("ar_rel_ir", ir_o, 64'h1000);
        check("ar_rel_pc", pc_o, 32'h0);

        // Address wrap at the top of the space, unaligned target
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        check("wr_adr", bus_adr_o, 32'hFFFF_FFFC);
        tick();
        check("wr_ir", ir_o, 64'hA000);
        check("wr_pc", pc_o, 32'hFFFF_FFFC);
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        check("wr_next_adr", bus_adr_o, 32'h0);
        tick();

        // Random traffic against the transaction-level model
        rst_i = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        rst_i = 1'b0;
        m_adr = 32'h0;
        m_pend = 1'b0;
        m_ir = 64'h0;
        m_pc = 32'h0;
        m_part.delete();
        for (int c = 0; c < 500; c++) begin
            r_stall = ($urandom_range(3) == 0);
            r_set   = ($urandom_range(15) == 0);
            r_tgt   = $urandom;
            r_ack   = ($urandom_range(2) != 0);
            drive(r_stall, r_set, r_tgt, r_ack);
            e_cyc = !m_pend && !r_set;
            check("rnd_cyc", bus_cyc_o, e_cyc);
            check("rnd_stb", bus_stb_o, e_cyc);
            if (e_cyc) check("rnd_adr", bus_adr_o, m_adr);
            if (r_set) begin
                m_adr = r_tgt & ~32'h3;
                m_part.delete();
                m_pend = 1'b0;
                m_ir = 64'h0;
            end else begin
                got = 1'b0;
                if (m_pend) begin
                    if (!r_stall) begin
                        m_ir = m_pir;
                        m_pc = m_ppc;
                        m_pend = 1'b0;
                        got = 1'b1;
                    end
                end else if (r_ack) begin
                    w = mem[m_adr[9:2]];
                    if (m_part.size() == 0) m_ipc = m_adr;
                    m_part.push_back(w);
                    m_adr = m_adr + 32'd4;
                    if (m_part.size() == 2 || !w[0]) begin
                        inst = (m_part.size() == 2) ? {m_part[1], m_part[0]} : {32'h0, m_part[0]};
                        m_part.delete();
                        if (r_stall) begin
                            m_pend = 1'b1;
                            m_pir = inst;
                            m_ppc = m_ipc;
                        end else begin
                            m_ir = inst;
                            m_pc = m_ipc;
                            got = 1'b1;
                        end
                    end
                end
                if (!r_stall && !got) m_ir = 64'h0;
            end
            tick();
            check("rnd_ir", ir_o, m_ir);
            if (m_ir != 64'h0) check("rnd_pc", pc_o, m_pc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the address of the first instruction fetched after reset.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 stall_i  input  1  downstream stall; ir_o/pc_o hold while high.
REQ-005 pc_set_i  input  1  redirect strobe, from branch/exception resolution.
REQ-006 pc_target_i  input  32  redirect address, sampled when pc_set_i=1.
REQ-007 bus_cyc_o  output  1  bus cycle active.
REQ-008 bus_stb_o  output  1  bus strobe; always equal to bus_cyc_o.
REQ-009 bus_adr_o  output  32  word address of the current read.
REQ-010 bus_sel_o  output  4  byte selects; constant 4'hF.
REQ-011 bus_we_o  output  1  write enable; constant 0.
REQ-012 bus_ack_i  input  1  read data valid this cycle.
REQ-013 bus_dat_i  input  32  read data.
REQ-014 ir_o  output  64  instruction to decode: [31:0] opcode word, [63:32] immediate word, 64'h0 = bubble.
REQ-015 pc_o  output  32  address of the opcode word of ir_o; undefined when ir_o=0.

Function
REQ-016 Internal fetch PC (fpc) shall advance by 4 on every accepted word (bus_ack_i=1 with bus_cyc_o=1); 32-bit wrap, 32'hFFFFFFFC+4 -> 32'h0.
REQ-017 Opcode word with bit 0 = 1 is long form: the next sequential word is fetched as the immediate, into ir[63:32]; with bit 0 = 0, ir[63:32] shall be 32'h0.
REQ-018 FSM states: F1 (fetch opcode word), F2 (fetch immediate word), HOLD (complete instruction parked, waiting on stall).
REQ-019 F1: bus_cyc_o=1, bus_adr_o=fpc; on ack, short form -> deliver (REQ-021) or HOLD if stall_i=1; long form -> latch opcode and its address, go to F2.
REQ-020 F2: bus_cyc_o=1, bus_adr_o=fpc; on ack -> deliver, or HOLD if stall_i=1.
REQ-021 Deliver: at the ack edge ir_o<=assembled instruction, pc_o<=opcode address, FSM returns to F1.
REQ-022 HOLD: bus_cyc_o=0; when stall_i=0, load parked instruction into ir_o/pc_o at the edge and go to F1.
REQ-023 bus_adr_o shall remain stable and bus_cyc_o asserted from request until ack or redirect.
REQ-024 In any edge where stall_i=0 and no instruction is delivered, ir_o<=64'h0 (bubble); pc_o holds.
REQ-025 While stall_i=1, ir_o and pc_o shall not change (except by redirect, REQ-026).
REQ-026 pc_set_i=1 has priority over all other events: at that edge fpc<=pc_target_i, FSM<=F1, ir_o<=64'h0, any parked or partial instruction discarded, and an ack in the same cycle ignored.
REQ-027 bus_cyc_o shall be 0 in the cycle in which pc_set_i=1 is presented.
REQ-028 Throughput with zero-wait ack (ack in the request cycle): one short instruction per clock, one long instruction per two clocks.
REQ-029 Latency: short instruction visible on ir_o at the edge following its ack; long instruction at the edge following the second ack.
REQ-030 pc_target_i[1:0] shall be ignored (forced to 2'b00).

Reset
REQ-031 While rst_i=1: fpc=RESET_PC, FSM=F1, ir_o=64'h0, pc_o=32'h0, bus_cyc_o=0, bus_stb_o=0.
REQ-032 Reset asserted mid-fetch shall drop bus_cyc_o immediately (asynchronously) and discard partial instruction.
REQ-033 First bus request shall occur in the first clock after rst_i deasserts, address RESET_PC.

Verification
REQ-034 Reset release, zero-wait memory with short words at 0x0,0x4,0x8 -> ir_o shows each word on consecutive edges, pc_o 0x0,0x4,0x8.
REQ-035 Long instruction 0x00000001 at 0x10, immediate 0xDEADBEEF at 0x14 -> single ir_o=64'hDEADBEEF_00000001, pc_o=0x10, then next at 0x18.
REQ-036 Two wait-states per ack -> bus_adr_o stable during waits, bubbles (64'h0) on ir_o between instructions.
REQ-037 stall_i high 3 cycles while next instruction completes -> ir_o held, bus_cyc_o low in HOLD, parked instruction appears one edge after stall_i falls.
REQ-038 pc_set_i=1 with target 0x100 during F2 with coincident ack -> ack discarded, ir_o=64'h0 next edge, next request address 0x100.
REQ-039 rst_i asserted during F2 -> bus_cyc_o falls without clock, after release fetch restarts at RESET_PC.
